// File: rtl/dpad_btn_conditioner.sv
// Input conditioner for the d-pad LED-matrix editor buttons.
// Each raw active-low pin is synchronised and debounced on its own. The block
// then produces a clean active-high level and a one-cycle press pulse. Buttons
// selected in REPEAT_MASK also auto-repeat their pulse while held.
// Ports:
//   clk             system clock
//   rst             asynchronous reset, active-low
//   btn_n_i         raw button pins, active-low, asynchronous; bit order {B,A,right,down,up,left}
//   level_o         debounced button state, 1 = pressed
//   press_pulse_o   one-clk pulse on accepted press and on each auto-repeat
//   any_pressed_o   OR of level_o
module dpad_btn_conditioner #(
  parameter int unsigned      N_BTN        = 6,
  parameter int unsigned      DB_CYCLES    = 250000,
  parameter int unsigned      REPEAT_DELAY = 5000000,
  parameter int unsigned      REPEAT_RATE  = 1250000,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = N_BTN'(6'b001111)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_pulse_o,
  output logic             any_pressed_o
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RC_W = $clog2(RMAX + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_LOAD  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RR_LOAD  = RC_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} rpt_state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] s_c;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [DB_W-1:0]  dbcnt_q [N_BTN];
  logic [DB_W-1:0]  dbcnt_d [N_BTN];
  logic [N_BTN-1:0] level_q;
  logic             any_q;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  rpt_state_e       state_q [N_BTN];
  rpt_state_e       state_d [N_BTN];
  logic [RC_W-1:0]  rcnt_q [N_BTN];
  logic [RC_W-1:0]  rcnt_d [N_BTN];

  // Two-flop synchroniser; reset value 1 means released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign s_c = ~sync2_q;

  // Debounce: a change must persist DB_CYCLES cycles; any bounce restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      dbcnt_d[i] = '0;
      if (s_c[i] != stable_q[i]) begin
        if (dbcnt_q[i] == DB_LAST) begin
          stable_d[i] = s_c[i];
        end else begin
          dbcnt_d[i] = dbcnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Repeat FSM next state. level_q holds the previous stable value, so
  // stable_q vs level_q flags the edge in the cycle before level_o moves.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (!stable_q[i] && level_q[i]) begin
        // Release wins over any repeat due this cycle.
        state_d[i] = IDLE;
        rcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (stable_q[i] && !level_q[i]) begin
              pulse_d[i] = 1'b1;
              if (REPEAT_MASK[i]) begin
                state_d[i] = DELAY;
                rcnt_d[i]  = RD_LOAD;
              end else begin
                state_d[i] = HELD;
              end
            end
          end
          DELAY, REPEAT: begin
            if (rcnt_q[i] == '0) begin
              pulse_d[i] = 1'b1;
              state_d[i] = REPEAT;
              rcnt_d[i]  = RR_LOAD;
            end else begin
              rcnt_d[i]  = rcnt_q[i] - RC_W'(1);
            end
          end
          HELD:    state_d[i] = HELD;
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  // Debounce, FSM and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= '0;
      level_q  <= '0;
      any_q    <= 1'b0;
      pulse_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        dbcnt_q[i] <= '0;
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
      end
    end else begin
      stable_q <= stable_d;
      level_q  <= stable_q;
      any_q    <= |stable_q;
      pulse_q  <= pulse_d;
      for (int i = 0; i < N_BTN; i++) begin
        dbcnt_q[i] <= dbcnt_d[i];
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  assign level_o       = level_q;
  assign press_pulse_o = pulse_q;
  assign any_pressed_o = any_q;

endmodule
